// File: rtl/move_command_ir_transmitter.sv
// Move-command IR transmitter.
// Latches a 12-bit move command and sends it REPEATS times as a pulse-width-coded
// IR frame: a start burst, then a gap and a burst for each of the 12 bits (LSB first),
// then a long frame gap. Bursts are modulated by a square-wave carrier.
module move_command_ir_transmitter #(
  parameter int unsigned UNIT_CYCLES         = 16200,
  parameter int unsigned CARRIER_HALF_PERIOD = 338,
  parameter int unsigned START_UNITS         = 4,
  parameter int unsigned ONE_UNITS           = 2,
  parameter int unsigned ZERO_UNITS          = 1,
  parameter int unsigned GAP_UNITS           = 1,
  parameter int unsigned FRAME_GAP_UNITS     = 75,
  parameter int unsigned REPEATS             = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        move_ready,
  input  logic [11:0] move_command,
  output logic        ir_out,
  output logic        envelope,
  output logic        busy,
  output logic        transmit_done,
  output logic        command_dropped,
  output logic [2:0]  state
);

  localparam int unsigned StartLen    = START_UNITS * UNIT_CYCLES;
  localparam int unsigned OneLen      = ONE_UNITS * UNIT_CYCLES;
  localparam int unsigned ZeroLen     = ZERO_UNITS * UNIT_CYCLES;
  localparam int unsigned GapLen      = GAP_UNITS * UNIT_CYCLES;
  localparam int unsigned FrameGapLen = FRAME_GAP_UNITS * UNIT_CYCLES;

  // The counter must hold the longest interval minus one.
  localparam int unsigned MaxA   = (StartLen > OneLen) ? StartLen : OneLen;
  localparam int unsigned MaxB   = (ZeroLen > GapLen) ? ZeroLen : GapLen;
  localparam int unsigned MaxC   = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned MaxLen = (MaxC > FrameGapLen) ? MaxC : FrameGapLen;
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  localparam int unsigned PhW  = (CARRIER_HALF_PERIOD > 1) ? $clog2(CARRIER_HALF_PERIOD) : 1;
  localparam int unsigned RepW = (REPEATS > 1) ? $clog2(REPEATS) : 1;

  // Counters load "length - 1" and count down to zero.
  localparam logic [CntW-1:0] StartLast    = CntW'(StartLen - 1);
  localparam logic [CntW-1:0] OneLast      = CntW'(OneLen - 1);
  localparam logic [CntW-1:0] ZeroLast     = CntW'(ZeroLen - 1);
  localparam logic [CntW-1:0] GapLast      = CntW'(GapLen - 1);
  localparam logic [CntW-1:0] FrameGapLast = CntW'(FrameGapLen - 1);
  localparam logic [PhW-1:0]  PhLast       = PhW'(CARRIER_HALF_PERIOD - 1);
  localparam logic [RepW-1:0] RepLast      = RepW'(REPEATS - 1);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StStartBurst = 3'd1,
    StBitGap     = 3'd2,
    StBitBurst   = 3'd3,
    StFrameGap   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [RepW-1:0] rep_q, rep_d;
  logic [11:0]     cmd_q, cmd_d;
  logic            env_q, env_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;
  logic            carrier_q, carrier_d;
  logic [PhW-1:0]  phase_q, phase_d;
  logic            ir_q, ir_d;

  // Frame sequencer: next state, interval counter, bit index and repeat count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    rep_d     = rep_q;
    cmd_d     = cmd_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (move_ready) begin
          cmd_d     = move_command;
          bit_idx_d = 4'd0;
          rep_d     = '0;
          cnt_d     = StartLast;
          state_d   = StStartBurst;
        end
      end
      StStartBurst: begin
        if (cnt_q == '0) begin
          cnt_d   = GapLast;
          state_d = StBitGap;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StBitGap: begin
        if (cnt_q == '0) begin
          cnt_d   = cmd_q[bit_idx_q] ? OneLast : ZeroLast;
          state_d = StBitBurst;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StBitBurst: begin
        if (cnt_q == '0) begin
          if (bit_idx_q == 4'd11) begin
            cnt_d   = FrameGapLast;
            state_d = StFrameGap;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            cnt_d     = GapLast;
            state_d   = StBitGap;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFrameGap: begin
        if (cnt_q == '0) begin
          if (rep_q == RepLast) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            rep_d     = rep_q + RepW'(1);
            bit_idx_d = 4'd0;
            cnt_d     = StartLast;
            state_d   = StStartBurst;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered status outputs follow the next state so they line up with state_q.
  always_comb begin
    env_d  = (state_d == StStartBurst) || (state_d == StBitBurst);
    busy_d = (state_d != StIdle);
    // A strobe while a transfer is in flight is discarded; flag it.
    drop_d = move_ready && (state_q != StIdle);
  end

  // Carrier: restart high on each rising envelope edge, else toggle every half period.
  always_comb begin
    carrier_d = carrier_q;
    phase_d   = phase_q;
    if (env_d && !env_q) begin
      carrier_d = 1'b1;
      phase_d   = '0;
    end else if (phase_q == PhLast) begin
      carrier_d = ~carrier_q;
      phase_d   = '0;
    end else begin
      phase_d = phase_q + PhW'(1);
    end
    ir_d = env_d & carrier_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 4'd0;
      rep_q     <= '0;
      cmd_q     <= 12'd0;
      env_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      carrier_q <= 1'b0;
      phase_q   <= '0;
      ir_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      rep_q     <= rep_d;
      cmd_q     <= cmd_d;
      env_q     <= env_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
      carrier_q <= carrier_d;
      phase_q   <= phase_d;
      ir_q      <= ir_d;
    end
  end

  assign ir_out          = ir_q;
  assign envelope        = env_q;
  assign busy            = busy_q;
  assign transmit_done   = done_q;
  assign command_dropped = drop_q;
  assign state           = state_q;

endmodule

// File: tb/tb_move_command_ir_transmitter.sv
// Scoreboard bench for move_command_ir_transmitter (UNIT_CYCLES=4, carrier half-period 1,
// frame gap 3 units, 2 repeats). Stimulus pushes expected bursts/done/drop events;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_move_command_ir_transmitter;

  typedef struct {
    int start;
    int width;
  } burst_t;

  typedef struct {
    int at;
    int blen;
  } done_t;

  logic        clk;
  logic        reset;
  logic        move_ready;
  logic [11:0] move_command;
  logic        ir_out;
  logic        envelope;
  logic        busy;
  logic        transmit_done;
  logic        command_dropped;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  burst_t exp_b[$];
  done_t  exp_d[$];
  int     exp_drop[$];

  // Hand-derived burst widths, LSB first.
  int w_a53[12] = '{8, 8, 4, 4, 8, 4, 8, 4, 4, 8, 4, 8};
  int w_0f0[12] = '{4, 4, 4, 4, 8, 8, 8, 8, 4, 4, 4, 4};

  move_command_ir_transmitter #(
    .UNIT_CYCLES        (4),
    .CARRIER_HALF_PERIOD(1),
    .FRAME_GAP_UNITS    (3),
    .REPEATS            (2)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .move_ready     (move_ready),
    .move_command   (move_command),
    .ir_out         (ir_out),
    .envelope       (envelope),
    .busy           (busy),
    .transmit_done  (transmit_done),
    .command_dropped(command_dropped),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: value of cyc during a clock period.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: actual=%0d expected=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a command in the current cycle and queue its two expected frames.
  task automatic send(input logic [11:0] c, input int w[12], input int done_off,
                      output int n);
    int     t;
    burst_t e;
    done_t  d;
    n            = cyc;
    move_command = c;
    move_ready   = 1'b1;
    t            = n + 1;
    for (int r = 0; r < 2; r++) begin
      e.start = t;
      e.width = 16;
      exp_b.push_back(e);
      t = t + 16;
      for (int b = 0; b < 12; b++) begin
        t       = t + 4;
        e.start = t;
        e.width = w[b];
        exp_b.push_back(e);
        t = t + w[b];
      end
      t = t + 12;
    end
    d.at   = n + done_off;
    d.blen = done_off - 1;
    exp_d.push_back(d);
    step();
    move_ready = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // Monitor state.
  int mon_start;
  int mon_pos;
  int mon_car_bad;
  int mon_busy_run;
  int mon_leak;
  logic mon_env_prev;

  initial begin
    burst_t e;
    done_t  d;
    int     x;
    mon_start    = 0;
    mon_pos      = 0;
    mon_car_bad  = 0;
    mon_busy_run = 0;
    mon_leak     = 0;
    mon_env_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!envelope && ir_out) mon_leak = mon_leak + 1;
      if (envelope) begin
        if (!mon_env_prev) begin
          mon_start   = cyc;
          mon_pos     = 0;
          mon_car_bad = 0;
        end
        if (ir_out != ((mon_pos % 2) == 0)) mon_car_bad = mon_car_bad + 1;
        mon_pos = mon_pos + 1;
      end else if (mon_env_prev) begin
        if (exp_b.size() == 0) begin
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL unexpected_burst: start=%0d width=%0d expected none", mon_start,
                   mon_pos);
        end else begin
          e = exp_b.pop_front();
          chk("burst_start", mon_start, e.start);
          chk("burst_width", mon_pos, e.width);
          chk("burst_carrier_errors", mon_car_bad, 0);
        end
      end
      mon_env_prev = envelope;

      if (busy) mon_busy_run = mon_busy_run + 1;
      if (transmit_done) begin
        if (exp_d.size() == 0) begin
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL unexpected_done: at=%0d expected none", cyc);
        end else begin
          d = exp_d.pop_front();
          chk("done_cycle", cyc, d.at);
          chk("busy_length", mon_busy_run, d.blen);
          chk("busy_at_done", int'(busy), 0);
        end
        mon_busy_run = 0;
      end
      if (command_dropped) begin
        if (exp_drop.size() == 0) begin
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL unexpected_drop: at=%0d expected none", cyc);
        end else begin
          x = exp_drop.pop_front();
          chk("drop_cycle", cyc, x);
        end
      end
      if (reset) mon_busy_run = 0;
    end
  end

  // Stimulus.
  initial begin
    int     n;
    int     m;
    int     act;
    burst_t keep[$];

    reset        = 1'b1;
    move_ready   = 1'b0;
    move_command = 12'h000;
    #1;
    repeat (3) step();
    chk("rst_ir_out", int'(ir_out), 0);
    chk("rst_envelope", int'(envelope), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(transmit_done), 0);
    chk("rst_dropped", int'(command_dropped), 0);
    chk("rst_state", int'(state), 0);
    reset = 1'b0;

    act = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ir_out || envelope || busy) act = act + 1;
    end
    chk("idle_activity", act, 0);

    // Full run of 12'hA53 with a dropped 12'hFFF mid-frame.
    send(12'hA53, w_a53, 297, n);
    chk("first_cycle_envelope", int'(envelope), 1);
    chk("first_cycle_busy", int'(busy), 1);
    chk("first_cycle_state", int'(state), 1);
    wait_until(n + 50);
    move_command = 12'hFFF;
    move_ready   = 1'b1;
    exp_drop.push_back(n + 51);
    step();
    move_ready = 1'b0;
    wait_until(n + 300);
    chk("run1_bursts_left", exp_b.size(), 0);
    chk("run1_done_left", exp_d.size(), 0);
    chk("run1_drop_left", exp_drop.size(), 0);
    chk("run1_idle_state", int'(state), 0);

    // Abort by reset, then restart with 12'h0F0.
    step();
    send(12'hA53, w_a53, 297, n);
    wait_until(n + 60);
    reset = 1'b1;
    step();
    reset = 1'b0;
    keep = {};
    foreach (exp_b[i]) if (exp_b[i].start <= n + 60) keep.push_back(exp_b[i]);
    exp_b = keep;
    exp_d.delete();
    chk("abort_envelope", int'(envelope), 0);
    chk("abort_ir_out", int'(ir_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_state", int'(state), 0);
    wait_until(n + 70);
    send(12'h0F0, w_0f0, 281, m);
    chk("restart_envelope", int'(envelope), 1);
    chk("restart_state", int'(state), 1);
    wait_until(m + 290);
    chk("run2_bursts_left", exp_b.size(), 0);
    chk("run2_done_left", exp_d.size(), 0);
    chk("run2_drop_left", exp_drop.size(), 0);
    chk("ir_out_in_gap", mon_leak, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
